timing_multi: RTL and testbench

Parametrised multi-channel timer, successor to the single-channel `timing` block. Sits behind the register file: `ro_*` control inputs come from register outputs, `rf_*` results go back for software readback. Each channel counts prescaled ticks up to a latched terminal count in one-shot, periodic or free-run mode. Per-channel sticky interrupt pending bits, masked and OR-reduced, form one interrupt line.

---
 rtl/timing_pkg.sv | 21 ++
 rtl/timing_channel.sv | 110 +++++++++++
 rtl/timing_multi.sv | 66 ++++++
 tb/tb_timing_multi.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/timing_pkg.sv
// timing_pkg: shared encodings for the multi-channel timer.
//   MODE_*   : 2-bit channel mode encodings (11 behaves as one-shot)
//   state_e  : per-channel FSM state
//   norm_mode: folds the reserved mode code onto one-shot at latch time
package timing_pkg;

  localparam logic [1:0] MODE_ONESHOT  = 2'b00;
  localparam logic [1:0] MODE_PERIODIC = 2'b01;
  localparam logic [1:0] MODE_FREERUN  = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_e;

  function automatic logic [1:0] norm_mode(input logic [1:0] m);
    return (m == 2'b11) ? MODE_ONESHOT : m;
  endfunction

endpackage

// File: rtl/timing_channel.sv
// timing_channel: one timer lane -- FSM, counter, latched config, sticky pend.
//   clk, reset   : clock, async active-high reset
//   i_tick       : shared prescaler tick
//   i_start      : start/restart pulse (latches i_mode/i_term)
//   i_halt       : halt pulse, wins over i_start
//   i_mode       : mode source, sampled only on an accepted start
//   i_term       : terminal-count source, sampled only on an accepted start
//   i_int_clr    : clear pend (a same-cycle event keeps it set)
//   o_running    : state == RUN
//   o_count      : current count
//   o_pend       : sticky interrupt pending
module timing_channel
  import timing_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_tick,
  input  logic             i_start,
  input  logic             i_halt,
  input  logic [1:0]       i_mode,
  input  logic [CNT_W-1:0] i_term,
  input  logic             i_int_clr,
  output logic             o_running,
  output logic [CNT_W-1:0] o_count,
  output logic             o_pend
);

  state_e           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_count, w_count_nxt;
  logic [CNT_W-1:0] r_term,  w_term_nxt;
  logic [1:0]       r_mode,  w_mode_nxt;
  logic             r_pend,  w_pend_nxt;
  logic [CNT_W-1:0] w_inc;
  logic [1:0]       w_mode_in;
  logic             w_start_ok;
  logic             w_evt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_count <= '0;
      r_term  <= '0;
      r_mode  <= MODE_ONESHOT;
      r_pend  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
      r_term  <= w_term_nxt;
      r_mode  <= w_mode_nxt;
      r_pend  <= w_pend_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_term_nxt  = r_term;
    w_mode_nxt  = r_mode;
    w_evt       = 1'b0;
    w_inc       = r_count + CNT_W'(1);
    w_mode_in   = norm_mode(i_mode);
    // A zero terminal count would never be reached in one-shot/periodic,
    // so such a start is dropped; free-run ignores the terminal count.
    w_start_ok  = i_start && !i_halt &&
                  ((w_mode_in == MODE_FREERUN) || (i_term != '0));

    if (i_halt) begin
      if (r_state == RUN) w_state_nxt = IDLE;
    end else if (w_start_ok) begin
      w_state_nxt = RUN;
      w_count_nxt = '0;
      w_term_nxt  = i_term;
      w_mode_nxt  = w_mode_in;
    end else if ((r_state == RUN) && i_tick) begin
      case (r_mode)
        MODE_PERIODIC: begin
          if (w_inc == r_term) begin
            w_count_nxt = '0;
            w_evt       = 1'b1;
          end else begin
            w_count_nxt = w_inc;
          end
        end
        MODE_FREERUN: begin
          w_count_nxt = w_inc;
          w_evt       = (r_count == '1);
        end
        default: begin
          if (w_inc == r_term) begin
            w_count_nxt = r_term;
            w_state_nxt = DONE;
            w_evt       = 1'b1;
          end else begin
            w_count_nxt = w_inc;
          end
        end
      endcase
    end

    // Set beats clear so a coincident clear cannot lose an event.
    w_pend_nxt = w_evt ? 1'b1 : (i_int_clr ? 1'b0 : r_pend);
  end

  assign o_running = (r_state == RUN);
  assign o_count   = r_count;
  assign o_pend    = r_pend;

endmodule

// File: rtl/timing_multi.sv
// timing_multi: NUM_CH independent timers sharing one prescaler.
//   clk, reset     : clock, async active-high reset
//   ro_trig_start  : [NUM_CH]        start/restart pulses
//   ro_trig_halt   : [NUM_CH]        halt pulses
//   ro_mode        : [2*NUM_CH]      channel i at [2i+1:2i]
//   ro_termcount   : [NUM_CH*CNT_W]  channel i at [CNT_W*i +: CNT_W]
//   ro_prescale    : [PRESC_W]       tick every ro_prescale+1 clocks
//   ro_int_en      : [NUM_CH]        interrupt mask
//   ro_int_clr     : [NUM_CH]        pend clear pulses
//   rf_status      : [NUM_CH]        channel running
//   rf_currcount   : [NUM_CH*CNT_W]  current counts
//   rf_int_pend    : [NUM_CH]        sticky pending bits
//   rf_int         : OR of enabled pending bits
module timing_multi
  import timing_pkg::*;
#(
  parameter int NUM_CH  = 4,
  parameter int CNT_W   = 32,
  parameter int PRESC_W = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_CH-1:0]       ro_trig_start,
  input  logic [NUM_CH-1:0]       ro_trig_halt,
  input  logic [2*NUM_CH-1:0]     ro_mode,
  input  logic [NUM_CH*CNT_W-1:0] ro_termcount,
  input  logic [PRESC_W-1:0]      ro_prescale,
  input  logic [NUM_CH-1:0]       ro_int_en,
  input  logic [NUM_CH-1:0]       ro_int_clr,
  output logic [NUM_CH-1:0]       rf_status,
  output logic [NUM_CH*CNT_W-1:0] rf_currcount,
  output logic [NUM_CH-1:0]       rf_int_pend,
  output logic                    rf_int
);

  logic [PRESC_W-1:0] r_presc;
  logic               w_tick;

  // >= rather than == so lowering ro_prescale below the running count
  // resynchronises on the next clock instead of waiting for a wrap.
  assign w_tick = (r_presc >= ro_prescale);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_presc <= '0;
    else       r_presc <= w_tick ? '0 : r_presc + PRESC_W'(1);
  end

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    timing_channel #(.CNT_W(CNT_W)) u_ch (
      .clk       (clk),
      .reset     (reset),
      .i_tick    (w_tick),
      .i_start   (ro_trig_start[gi]),
      .i_halt    (ro_trig_halt[gi]),
      .i_mode    (ro_mode[2*gi +: 2]),
      .i_term    (ro_termcount[CNT_W*gi +: CNT_W]),
      .i_int_clr (ro_int_clr[gi]),
      .o_running (rf_status[gi]),
      .o_count   (rf_currcount[CNT_W*gi +: CNT_W]),
      .o_pend    (rf_int_pend[gi])
    );
  end

  assign rf_int = |(rf_int_pend & ro_int_en);

endmodule

// File: tb/tb_timing_multi.sv
module tb_timing_multi;
  localparam int NCH = 4;
  localparam int CW  = 4;
  localparam int PW  = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic [NCH-1:0]    ro_trig_start, ro_trig_halt, ro_int_en, ro_int_clr;
  logic [2*NCH-1:0]  ro_mode;
  logic [NCH*CW-1:0] ro_termcount;
  logic [PW-1:0]     ro_prescale;
  logic [NCH-1:0]    rf_status, rf_int_pend;
  logic [NCH*CW-1:0] rf_currcount;
  logic              rf_int;

  int n_pass = 0;
  int n_tot  = 0;

  timing_multi #(.NUM_CH(NCH), .CNT_W(CW), .PRESC_W(PW)) dut (
    .clk(clk), .reset(reset),
    .ro_trig_start(ro_trig_start), .ro_trig_halt(ro_trig_halt),
    .ro_mode(ro_mode), .ro_termcount(ro_termcount), .ro_prescale(ro_prescale),
    .ro_int_en(ro_int_en), .ro_int_clr(ro_int_clr),
    .rf_status(rf_status), .rf_currcount(rf_currcount),
    .rf_int_pend(rf_int_pend), .rf_int(rf_int)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic logic [CW-1:0] cnt(input int c);
    return rf_currcount[CW*c +: CW];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int c, input logic [1:0] m, input logic [CW-1:0] t);
    ro_mode[2*c +: 2]       = m;
    ro_termcount[CW*c +: CW] = t;
  endtask

  task automatic start(input int c);
    ro_trig_start[c] = 1'b1; tick(); ro_trig_start[c] = 1'b0;
  endtask

  task automatic halt(input int c);
    ro_trig_halt[c] = 1'b1; tick(); ro_trig_halt[c] = 1'b0;
  endtask

  task automatic clr(input int c);
    ro_int_clr[c] = 1'b1; tick(); ro_int_clr[c] = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    ro_trig_start = '0; ro_trig_halt = '0; ro_int_en = '0; ro_int_clr = '0;
    ro_mode = '0; ro_termcount = '0; ro_prescale = '0;
    #2;
    n_tot++;
    if ({rf_status, rf_currcount, rf_int_pend, rf_int} !== '0)
      $display("FAIL reset_outputs: got st=%b cnt=%h pend=%b int=%b want all 0",
               rf_status, rf_currcount, rf_int_pend, rf_int);
    else n_pass++;
    tick(); tick();
    reset = 1'b0;
    tick();
    n_tot++;
    if ({rf_status, rf_currcount, rf_int_pend} !== '0)
      $display("FAIL reset_release: got st=%b cnt=%h pend=%b want 0",
               rf_status, rf_currcount, rf_int_pend);
    else n_pass++;
  endtask

  task automatic test_oneshot();
    ro_prescale = '0; ro_int_en = '0;
    set_ch(0, 2'b00, 4'd10);
    start(0);
    n_tot++;
    if (cnt(0) !== 4'd0 || rf_status[0] !== 1'b1)
      $display("FAIL os_start: cnt=%0d st=%b want 0/1", cnt(0), rf_status[0]);
    else n_pass++;
    for (int k = 1; k <= 10; k++) begin
      tick();
      n_tot++;
      if (cnt(0) !== CW'(k) || rf_int_pend[0] !== (k == 10) || rf_status[0] !== (k < 10))
        $display("FAIL os_step%0d: cnt=%0d pend=%b st=%b want %0d/%b/%b",
                 k, cnt(0), rf_int_pend[0], rf_status[0], k, k == 10, k < 10);
      else n_pass++;
    end
    n_tot++;
    if (rf_int !== 1'b0) $display("FAIL os_int_masked: got %b want 0", rf_int);
    else n_pass++;
    ro_int_en[0] = 1'b1;
    #1;
    n_tot++;
    if (rf_int !== 1'b1) $display("FAIL os_int_enabled: got %b want 1", rf_int);
    else n_pass++;
    repeat (3) tick();
    n_tot++;
    if (cnt(0) !== 4'd10 || rf_status[0] !== 1'b0)
      $display("FAIL os_hold: cnt=%0d st=%b want 10/0", cnt(0), rf_status[0]);
    else n_pass++;
    clr(0);
    n_tot++;
    if (rf_int_pend[0] !== 1'b0 || rf_int !== 1'b0)
      $display("FAIL os_clear: pend=%b int=%b want 0/0", rf_int_pend[0], rf_int);
    else n_pass++;
    ro_int_en = '0;
  endtask

  task automatic test_periodic();
    set_ch(1, 2'b01, 4'd3);
    start(1);
    for (int k = 1; k <= 7; k++) begin
      if (k == 4) ro_int_clr[1] = 1'b1;
      tick();
      ro_int_clr[1] = 1'b0;
      n_tot++;
      if (cnt(1) !== CW'(k % 3) || rf_int_pend[1] !== ((k == 3) || (k >= 6)) || rf_status[1] !== 1'b1)
        $display("FAIL per_step%0d: cnt=%0d pend=%b st=%b want %0d/%b/1",
                 k, cnt(1), rf_int_pend[1], rf_status[1], k % 3, (k == 3) || (k >= 6));
      else n_pass++;
    end
    halt(1); clr(1);
  endtask

  task automatic run_presc(input int p, input int n, input string tag);
    int t, t1, t2, lo, hi;
    ro_prescale = PW'(p);
    set_ch(2, 2'b00, CW'(n));
    clr(2);
    start(2);
    t = 0; t1 = -1; t2 = -1;
    while (rf_status[2] && t < 200) begin
      tick(); t++;
      if (cnt(2) == 4'd1 && t1 < 0) t1 = t;
      if (cnt(2) == 4'd2 && t2 < 0) t2 = t;
    end
    lo = (n - 1) * (p + 1) + 1;
    hi = n * (p + 1);
    n_tot++;
    if (t < lo || t > hi || rf_int_pend[2] !== 1'b1 || cnt(2) !== CW'(n))
      $display("FAIL %s: p=%0d n=%0d done after %0d clocks pend=%b cnt=%0d want %0d..%0d",
               tag, p, n, t, rf_int_pend[2], cnt(2), lo, hi);
    else n_pass++;
    if (n >= 2) begin
      n_tot++;
      if (t2 - t1 != p + 1)
        $display("FAIL %s_step: tick spacing %0d want %0d", tag, t2 - t1, p + 1);
      else n_pass++;
    end
  endtask

  task automatic test_prescale();
    run_presc(4, 2, "presc4");
    for (int i = 0; i < 6; i++)
      run_presc($urandom_range(0, 6), $urandom_range(1, 5), "presc_rand");
    ro_prescale = '0;
    clr(2);
  endtask

  task automatic test_halt();
    set_ch(3, 2'b00, 4'd12);
    start(3);
    repeat (5) tick();
    halt(3);
    n_tot++;
    if (rf_status[3] !== 1'b0 || cnt(3) !== 4'd5)
      $display("FAIL halt: st=%b cnt=%0d want 0/5", rf_status[3], cnt(3));
    else n_pass++;
    repeat (3) tick();
    ro_trig_start[3] = 1'b1; ro_trig_halt[3] = 1'b1;
    tick();
    ro_trig_start[3] = 1'b0; ro_trig_halt[3] = 1'b0;
    n_tot++;
    if (rf_status[3] !== 1'b0 || cnt(3) !== 4'd5)
      $display("FAIL start_halt: st=%b cnt=%0d want 0/5", rf_status[3], cnt(3));
    else n_pass++;
    start(3);
    repeat (12) tick();
    halt(3);
    n_tot++;
    if (rf_status[3] !== 1'b0 || cnt(3) !== 4'd12 || rf_int_pend[3] !== 1'b1)
      $display("FAIL done_halt: st=%b cnt=%0d pend=%b want 0/12/1",
               rf_status[3], cnt(3), rf_int_pend[3]);
    else n_pass++;
    start(3);
    n_tot++;
    if (rf_status[3] !== 1'b1 || cnt(3) !== 4'd0)
      $display("FAIL restart: st=%b cnt=%0d want 1/0", rf_status[3], cnt(3));
    else n_pass++;
    halt(3); clr(3);
  endtask

  task automatic test_freerun_term0();
    logic [CW-1:0] c0;
    set_ch(0, 2'b10, 4'd5);
    start(0);
    for (int k = 1; k <= 17; k++) begin
      tick();
      n_tot++;
      if (cnt(0) !== CW'(k % 16) || rf_int_pend[0] !== (k >= 16))
        $display("FAIL free_step%0d: cnt=%0d pend=%b want %0d/%b",
                 k, cnt(0), rf_int_pend[0], k % 16, k >= 16);
      else n_pass++;
    end
    halt(0); clr(0);
    c0 = cnt(0);
    set_ch(0, 2'b00, 4'd0);
    start(0);
    n_tot++;
    if (rf_status[0] !== 1'b0 || cnt(0) !== c0)
      $display("FAIL term0_oneshot: st=%b cnt=%0d want 0/%0d", rf_status[0], cnt(0), c0);
    else n_pass++;
    set_ch(1, 2'b01, 4'd5);
    start(1);
    tick(); tick();
    set_ch(1, 2'b01, 4'd0);
    start(1);
    n_tot++;
    if (rf_status[1] !== 1'b1 || cnt(1) !== 4'd3)
      $display("FAIL term0_running: st=%b cnt=%0d want 1/3", rf_status[1], cnt(1));
    else n_pass++;
    halt(1); clr(1);
  endtask

  task automatic test_clr_coincident();
    set_ch(1, 2'b01, 4'd3);
    start(1);
    tick(); tick();
    ro_int_clr[1] = 1'b1;
    tick();
    ro_int_clr[1] = 1'b0;
    n_tot++;
    if (rf_int_pend[1] !== 1'b1 || cnt(1) !== 4'd0)
      $display("FAIL clr_vs_set: pend=%b cnt=%0d want 1/0", rf_int_pend[1], cnt(1));
    else n_pass++;
    halt(1); clr(1);
  endtask

  task automatic test_async_reset();
    set_ch(0, 2'b10, 4'd0);
    set_ch(1, 2'b00, 4'd2);
    ro_int_en = '1;
    ro_trig_start = 4'b0011; tick(); ro_trig_start = '0;
    repeat (7) tick();
    n_tot++;
    if (cnt(0) !== 4'd7 || rf_int_pend[1] !== 1'b1 || rf_int !== 1'b1)
      $display("FAIL pre_reset: cnt=%0d pend1=%b int=%b want 7/1/1", cnt(0), rf_int_pend[1], rf_int);
    else n_pass++;
    #2 reset = 1'b1;
    #1;
    n_tot++;
    if ({rf_status, rf_currcount, rf_int_pend, rf_int} !== '0)
      $display("FAIL async_reset: st=%b cnt=%h pend=%b int=%b want all 0",
               rf_status, rf_currcount, rf_int_pend, rf_int);
    else n_pass++;
    tick();
    reset = 1'b0;
    tick(); tick();
    n_tot++;
    if ({rf_status, rf_currcount, rf_int_pend, rf_int} !== '0)
      $display("FAIL post_reset: st=%b cnt=%h pend=%b int=%b want all 0",
               rf_status, rf_currcount, rf_int_pend, rf_int);
    else n_pass++;
    ro_int_en = '0;
  endtask

  task automatic test_random();
    int c, m, n, kmax;
    logic en, ok, ep, es, ei;
    logic [CW-1:0] prev, ec;
    for (int it = 0; it < 20; it++) begin
      ro_prescale = '0;
      ro_trig_halt = '1; tick(); ro_trig_halt = '0;
      ro_int_clr = '1; tick(); ro_int_clr = '0;
      c = $urandom_range(0, NCH - 1);
      m = $urandom_range(0, 3);
      n = $urandom_range(0, 15);
      en = 1'($urandom);
      ro_int_en = '0;
      ro_int_en[c] = en;
      set_ch(c, 2'(m), CW'(n));
      prev = cnt(c);
      start(c);
      // Source registers change after start; the running channel must not care.
      set_ch(c, 2'($urandom), CW'($urandom));
      ok = (m == 2) || (n != 0);
      kmax = $urandom_range(1, 40);
      for (int k = 0; k <= kmax; k++) begin
        if (k > 0) tick();
        if (!ok) begin
          ec = prev; ep = 1'b0; es = 1'b0;
        end else if (m == 1) begin
          ec = CW'(k % n); ep = (k >= n); es = 1'b1;
        end else if (m == 2) begin
          ec = CW'(k % 16); ep = (k >= 16); es = 1'b1;
        end else begin
          ec = (k < n) ? CW'(k) : CW'(n); ep = (k >= n); es = (k < n);
        end
        ei = ep & en;
        n_tot++;
        if (cnt(c) !== ec || rf_int_pend[c] !== ep || rf_status[c] !== es || rf_int !== ei)
          $display("FAIL rand it%0d ch%0d m%0d n%0d k%0d: cnt/pend/st/int=%0d/%b/%b/%b want %0d/%b/%b/%b",
                   it, c, m, n, k, cnt(c), rf_int_pend[c], rf_status[c], rf_int, ec, ep, es, ei);
        else n_pass++;
      end
    end
    ro_trig_halt = '1; tick(); ro_trig_halt = '0;
    ro_int_en = '0;
  endtask

  initial begin
    test_reset();
    test_oneshot();
    test_periodic();
    test_prescale();
    test_halt();
    test_freerun_term0();
    test_clr_coincident();
    test_random();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
